// File: rtl/multiplier_hilo_if.sv
// ---------------------------------------------------------------------------
// multiplier_hilo_if
// Bundles the operation/data bus of the HI/LO multiplier.
//   signal  : 6-bit operation code from the ALU control stage
//   dataA   : 32-bit unsigned multiplicand
//   dataB   : 32-bit unsigned multiplier
//   hi, lo  : committed HI/LO registers
//   dataOut : MFHI/MFLO read data
//   busy    : multiply in progress or awaiting commit
//   done    : product ready, awaiting commit
// master = the control stage that issues operations; slave = the multiplier.
// ---------------------------------------------------------------------------
interface multiplier_hilo_if;
    logic [5:0]  signal;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] dataOut;
    logic        busy;
    logic        done;

    modport master (
        output signal, dataA, dataB,
        input  hi, lo, dataOut, busy, done
    );

    modport slave (
        input  signal, dataA, dataB,
        output hi, lo, dataOut, busy, done
    );
endinterface

// File: rtl/multiplier_hilo.sv
// ---------------------------------------------------------------------------
// multiplier_hilo
// 32x32 unsigned shift-add multiplier (one bit per cycle) with MIPS-style
// HI/LO result registers.
//   clk   : single clock, all state updates on posedge
//   reset : asynchronous, active-high
//   bus   : multiplier_hilo_if.slave (signal, dataA, dataB in;
//           hi, lo, dataOut, busy, done out)
// Flow: MULTU in IDLE starts 32 RUN steps. The result lands in HI/LO either
// on the last step (when HILO_LOAD was seen during RUN or on that step) or
// later from WAIT_LOAD on HILO_LOAD. Any unknown opcode during RUN aborts.
// ---------------------------------------------------------------------------
module multiplier_hilo #(
    parameter logic [5:0] MULTU     = 6'b011001,
    parameter logic [5:0] HILO_LOAD = 6'b111111,
    parameter logic [5:0] MFHI      = 6'b010000,
    parameter logic [5:0] MFLO      = 6'b010010
) (
    input logic              clk,
    input logic              reset,
    multiplier_hilo_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        WAIT_LOAD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [63:0] product;
    logic [31:0] multiplicand;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [5:0]  count;
    logic        pending;

    // Step datapath and FSM control strobes.
    logic [32:0] sum;
    logic [63:0] product_step;
    logic        last_step;
    logic        start;
    logic        step;
    logic        commit_step;
    logic        commit_wait;

    // Next-state / control decode.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        // The 33rd bit keeps the carry of upper+multiplicand; it becomes
        // product[63] after the shift, so no bit of the result is lost.
        sum          = product[0] ? ({1'b0, product[63:32]} + {1'b0, multiplicand})
                                  : {1'b0, product[63:32]};
        product_step = {sum, product[31:1]};
        last_step    = (count == 6'd31);

        state_next  = state;
        start       = 1'b0;
        step        = 1'b0;
        commit_step = 1'b0;
        commit_wait = 1'b0;

        case (state)
            IDLE: begin
                // HILO_LOAD is deliberately ignored here.
                if (bus.signal == MULTU) begin
                    start      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (bus.signal == MULTU || bus.signal == HILO_LOAD) begin
                    step = 1'b1;
                    if (last_step) begin
                        if (pending || bus.signal == HILO_LOAD) begin
                            commit_step = 1'b1;
                            state_next  = IDLE;
                        end else begin
                            state_next = WAIT_LOAD;
                        end
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT_LOAD: begin
                if (bus.signal == HILO_LOAD) begin
                    commit_wait = 1'b1;
                    state_next  = IDLE;
                end else if (bus.signal == MULTU) begin
                    start      = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            product      <= '0;
            multiplicand <= '0;
            count        <= '0;
            pending      <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
        end else begin
            if (start) begin
                multiplicand <= bus.dataA;
                product      <= {32'h0, bus.dataB};
                count        <= '0;
                pending      <= 1'b0;
            end else if (step) begin
                product <= product_step;
                count   <= count + 6'd1;
                if (bus.signal == HILO_LOAD) begin
                    pending <= 1'b1;
                end
            end

            // Early commit takes the freshly stepped product, not the
            // registered one, so HI/LO update on the 32nd step itself.
            if (commit_step) begin
                hi_q <= product_step[63:32];
                lo_q <= product_step[31:0];
            end else if (commit_wait) begin
                hi_q <= product[63:32];
                lo_q <= product[31:0];
            end
        end
    end

    // Reads only ever see committed HI/LO, never the running product.
    always_comb begin
        bus.dataOut = 32'h0;
        if (bus.signal == MFHI) begin
            bus.dataOut = hi_q;
        end else if (bus.signal == MFLO) begin
            bus.dataOut = lo_q;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state == RUN) || (state == WAIT_LOAD);
    assign bus.done = (state == WAIT_LOAD);

endmodule

// File: tb/tb_multiplier_hilo.sv
// ---------------------------------------------------------------------------
// tb_multiplier_hilo
// Self-checking bench for multiplier_hilo. Expected HI/LO values are pushed
// to a scoreboard queue when a multiply that should commit is issued; a
// monitor pops and compares whenever HI/LO change.
// ---------------------------------------------------------------------------
module tb_multiplier_hilo;

    localparam logic [5:0] MULTU     = 6'b011001;
    localparam logic [5:0] HILO_LOAD = 6'b111111;
    localparam logic [5:0] MFHI      = 6'b010000;
    localparam logic [5:0] MFLO      = 6'b010010;
    localparam logic [5:0] ADD       = 6'b100000;
    localparam logic [5:0] NOP       = 6'b000000;

    logic clk;
    logic reset;

    multiplier_hilo_if bus ();

    multiplier_hilo dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] sb[$];
    logic [63:0] prev_hilo = 64'h0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Scoreboard monitor: any change of HI/LO must match the next queued result.
    always @(negedge clk) begin
        logic [63:0] cur;
        logic [63:0] exp;
        cur = {bus.hi, bus.lo};
        if (!reset && cur !== prev_hilo) begin
            if (sb.size() == 0) begin
                check("unexpected_commit", cur, prev_hilo);
            end else begin
                exp = sb.pop_front();
                check("sb_hilo", cur, exp);
            end
            prev_hilo = cur;
        end
    end

    // One full multiply. commit_at = 0: commit from WAIT_LOAD; otherwise a
    // single HILO_LOAD is driven on RUN step commit_at (1..32).
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int commit_at);
        logic [63:0] exp;
        exp = 64'(a) * 64'(b);
        sb.push_back(exp);
        bus.signal = MULTU;
        bus.dataA  = a;
        bus.dataB  = b;
        @(posedge clk); #1;
        check("busy_start", 64'(bus.busy), 64'h1);
        bus.dataA = ~a;   // operands must already be captured
        bus.dataB = ~b;
        for (int s = 1; s <= 32; s++) begin
            bus.signal = (s == commit_at) ? HILO_LOAD : MULTU;
            if (s == 32) begin
                check("done_before_last", 64'(bus.done), 64'h0);
            end
            @(posedge clk); #1;
        end
        if (commit_at == 0) begin
            check("done_wait", 64'(bus.done), 64'h1);
            check("busy_wait", 64'(bus.busy), 64'h1);
            bus.signal = NOP;
            @(posedge clk); #1;
            check("done_hold", 64'(bus.done), 64'h1);
            bus.signal = MFLO;
            #1;
            check("mflo_in_wait", 64'(bus.dataOut), 64'(prev_hilo[31:0]));
            bus.signal = HILO_LOAD;
            @(posedge clk); #1;
        end
        check("busy_after", 64'(bus.busy), 64'h0);
        check("done_after", 64'(bus.done), 64'h0);
        check("hilo", {bus.hi, bus.lo}, exp);
        bus.signal = MFLO;
        #1;
        check("mflo", 64'(bus.dataOut), 64'(exp[31:0]));
        bus.signal = MFHI;
        #1;
        check("mfhi", 64'(bus.dataOut), 64'(exp[63:32]));
        bus.signal = ADD;
        #1;
        check("dataout_other", 64'(bus.dataOut), 64'h0);
        bus.signal = NOP;
        @(negedge clk); #1;
        check("sb_drained", 64'(sb.size()), 64'h0);
    endtask

    initial begin
        logic [63:0] pre;
        reset      = 1'b1;
        bus.signal = MFHI;
        bus.dataA  = '0;
        bus.dataB  = '0;
        #1;
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_done", 64'(bus.done), 64'h0);
        check("rst_dataout", 64'(bus.dataOut), 64'h0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'h0);
        bus.signal = NOP;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Basic, carry retention, early commit on step 32, pending from step 5.
        run_mul(32'd3, 32'd5, 0);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_mul(32'h0001_0000, 32'h0001_0000, 32);
        run_mul(32'h1234_5678, 32'h9ABC_DEF1, 5);
        run_mul(32'd7, 32'h8000_0003, 0);

        // HILO_LOAD in IDLE must not touch HI/LO.
        pre = {bus.hi, bus.lo};
        bus.signal = HILO_LOAD;
        repeat (3) @(posedge clk);
        #1;
        check("idle_load_busy", 64'(bus.busy), 64'h0);
        check("idle_load_hilo", {bus.hi, bus.lo}, pre);

        // Abort with ADD on RUN step 10.
        bus.signal = MULTU;
        bus.dataA  = 32'd100;
        bus.dataB  = 32'd200;
        @(posedge clk); #1;
        for (int s = 1; s <= 9; s++) begin
            @(posedge clk); #1;
        end
        bus.signal = MFHI;
        #1;
        check("mfhi_in_run", 64'(bus.dataOut), 64'(pre[63:32]));
        bus.signal = ADD;
        @(posedge clk); #1;
        check("abort_busy", 64'(bus.busy), 64'h0);
        check("abort_hilo", {bus.hi, bus.lo}, pre);
        bus.signal = NOP;
        @(posedge clk); #1;
        check("abort_stay_idle", 64'(bus.busy), 64'h0);

        // Asynchronous reset between edges at RUN step 20.
        bus.signal = MULTU;
        bus.dataA  = 32'd5;
        bus.dataB  = 32'd5;
        @(posedge clk); #1;
        for (int s = 1; s <= 19; s++) begin
            @(posedge clk); #1;
        end
        #1 reset = 1'b1;
        prev_hilo = 64'h0;
        bus.signal = MFHI;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'h0);
        check("midrst_hilo", {bus.hi, bus.lo}, 64'h0);
        check("midrst_dataout", 64'(bus.dataOut), 64'h0);
        reset      = 1'b0;
        bus.signal = NOP;
        @(posedge clk); #1;
        run_mul(32'd2, 32'd2, 0);

        // Restart from WAIT_LOAD: 6*7 is discarded, only 2*9 commits.
        bus.signal = MULTU;
        bus.dataA  = 32'd6;
        bus.dataB  = 32'd7;
        @(posedge clk); #1;
        for (int s = 1; s <= 32; s++) begin
            @(posedge clk); #1;
        end
        check("restart_done", 64'(bus.done), 64'h1);
        sb.push_back(64'd18);
        bus.dataA = 32'd2;
        bus.dataB = 32'd9;
        @(posedge clk); #1;
        check("restart_run", 64'(bus.done), 64'h0);
        for (int s = 1; s <= 32; s++) begin
            @(posedge clk); #1;
        end
        check("restart_done2", 64'(bus.done), 64'h1);
        bus.signal = HILO_LOAD;
        @(posedge clk); #1;
        check("restart_hilo", {bus.hi, bus.lo}, 64'd18);
        bus.signal = NOP;
        @(negedge clk); #1;
        check("restart_sb_drained", 64'(sb.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multiplier_hilo.md
MULTIPLIER_HILO -- requirements
Module: multiplier_hilo

Interface
REQ-001 Parameters: MULTU = 6'b011001 (start multiply); HILO_LOAD = 6'b111111 (commit product to HI/LO); MFHI = 6'b010000 (read HI); MFLO = 6'b010010 (read LO).
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 signal  input  6  operation code from the ALU control stage.
REQ-005 dataA  input  32  multiplicand, unsigned.
REQ-006 dataB  input  32  multiplier, unsigned.
REQ-007 hi  output  32  HI register.
REQ-008 lo  output  32  LO register.
REQ-009 dataOut  output  32  MFHI/MFLO read data.
REQ-010 busy  output  1  high in RUN and WAIT_LOAD.
REQ-011 done  output  1  high in WAIT_LOAD only.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN and WAIT_LOAD.
REQ-013 In IDLE, a posedge with signal==MULTU SHALL do the following, then enter RUN:
- capture dataA into a 32-bit multiplicand register;
- load a 64-bit product register with {32'h0, dataB};
- clear the 6-bit iteration counter and the pending flag.
REQ-014 In RUN, each posedge SHALL perform one shift-add step:
- if product[0]==1, form a 33-bit sum of product[63:32] + multiplicand;
- shift {sum_or_upper, product[31:0]} right by one into product;
- increment the counter.
REQ-015 The carry SHALL be retained in the 33-bit sum so that no product bit is lost.
REQ-016 After exactly 32 RUN steps, product SHALL equal dataA*dataB as a 64-bit unsigned value, and the FSM SHALL leave RUN on that 32nd posedge.
REQ-017 In RUN, signal==HILO_LOAD SHALL set the pending flag and continue the iteration (early commit request).
REQ-018 In RUN, any signal other than MULTU or HILO_LOAD SHALL abort to IDLE on that posedge, leaving hi/lo unchanged.
REQ-019 On the 32nd RUN step, if the pending flag is set or signal==HILO_LOAD, the block SHALL write the final product to hi/lo on that same posedge and go to IDLE; otherwise it SHALL go to WAIT_LOAD.
REQ-020 In WAIT_LOAD, signal==HILO_LOAD SHALL write hi <= product[63:32] and lo <= product[31:0], then go to IDLE.
REQ-021 In WAIT_LOAD, signal==MULTU SHALL discard the uncommitted product and restart as in REQ-013.
REQ-022 In WAIT_LOAD, any other signal SHALL hold state.
REQ-023 In IDLE, a signal of HILO_LOAD SHALL be ignored; hi/lo change only through REQ-019 or REQ-020.
REQ-024 Minimum latency SHALL be 33 posedges from MULTU sampled in IDLE to hi/lo updated, when HILO_LOAD is present by the 32nd RUN step.
REQ-025 dataOut SHALL be combinational:
- hi when signal==MFHI;
- lo when signal==MFLO;
- 32'h0 otherwise.
REQ-026 MFHI/MFLO reads SHALL be valid in any state and SHALL return the last committed hi/lo, never the in-progress product.
REQ-027 busy and done SHALL be decoded directly from the state register (Moore outputs).

Reset
REQ-028 Assertion of reset SHALL immediately, without waiting for clk, set:
- state = IDLE;
- hi, lo, product, multiplicand and counter = 0;
- pending flag = 0.
REQ-029 While reset is held, busy and done SHALL read 0, and dataOut SHALL read 0 for any signal.
REQ-030 Reset asserted mid-RUN or in WAIT_LOAD SHALL discard the operation, with no commit to hi/lo.
REQ-031 After reset deasserts, the first MULTU SHALL start cleanly per REQ-013.

Verification
REQ-032 Basic multiply: dataA=3, dataB=5, MULTU for 32 cycles, then HILO_LOAD -> done high after the 32nd step; after load hi=0, lo=15; MFLO gives dataOut=15.
REQ-033 Maximum operands: dataA=dataB=32'hFFFFFFFF, full sequence -> hi=32'hFFFFFFFE, lo=32'h00000001 (carry retention).
REQ-034 Early commit: HILO_LOAD driven on RUN step 32 with dataA=32'h10000, dataB=32'h10000 -> hi=1, lo=0 on that posedge; state IDLE; WAIT_LOAD never entered.
REQ-035 Abort: hi=7, lo=9 preloaded, new MULTU, then signal=ADD (6'b100000) at RUN step 10 -> IDLE next posedge, busy=0; hi=7, lo=9 unchanged.
REQ-036 Reset mid-operation: async reset pulse between edges at RUN step 20 -> busy=0, hi=lo=0 immediately; a following 2*2 sequence yields lo=4.
REQ-037 Restart: MULTU 6*7 reaches WAIT_LOAD, then MULTU with 2*9 before any HILO_LOAD -> after completion and load, lo=18 and 42 is never written.
